// File: rtl/axis_pkt_queue_splitter.sv
// axis_pkt_queue_splitter
// Accepts AXI-Stream packets and prepends one metadata line to each packet.
// The metadata line holds the timestamp and the low 64 bits of tuser. Each
// packet gets a queue ID from a selectable split policy. Header and data
// lines are buffered in a fall-through FIFO that carries per-line QID,
// header and end-of-packet sideband. Per-queue packet counters are kept.
module axis_pkt_queue_splitter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 4,
    parameter int NUM_QUEUES_BITS      = $clog2(NUM_QUEUES),
    parameter int FIFO_DEPTH_BITS      = 5,
    parameter int TS_WIDTH             = 64,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    input  logic                                 fifo_rd_en,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       fifo_dout,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     fifo_dout_strb,
    output logic                                 fifo_dout_hdr,
    output logic                                 fifo_dout_last,
    output logic [NUM_QUEUES_BITS-1:0]           fifo_dout_qid,
    output logic                                 fifo_empty,
    input  logic [1:0]                           split_mode,
    input  logic [32*(NUM_QUEUES-1)-1:0]         split_ratio,
    input  logic                                 clear_counters,
    output logic [32*NUM_QUEUES-1:0]             pkt_count
);

    localparam int STRB_W     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int QB         = NUM_QUEUES_BITS;
    localparam int LINE_W     = C_S_AXIS_DATA_WIDTH + STRB_W + 2 + QB;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;

    // Line layout, LSB first: qid, last, hdr, strb, data
    localparam int POS_LAST = QB;
    localparam int POS_HDR  = QB + 1;
    localparam int POS_STRB = QB + 2;
    localparam int POS_DATA = QB + 2 + STRB_W;

    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE   = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_FULL  = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ZERO  = (FIFO_DEPTH_BITS+1)'(0);
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE   = FIFO_DEPTH_BITS'(1);
    localparam logic [QB-1:0]              QID_ONE   = QB'(1);
    localparam logic [QB-1:0]              QID_LAST  = QB'(NUM_QUEUES - 1);
    localparam logic [TS_WIDTH-1:0]        TS_ONE    = TS_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_HDR = 1'b0,
        ST_PKT = 1'b1
    } state_t;

    // Galois-free Fibonacci step: shift right, feedback taps 31,6,4,2,1,0
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic fb;
        fb = cur[31] ^ cur[6] ^ cur[4] ^ cur[2] ^ cur[1] ^ cur[0];
        return {fb, cur[31:1]};
    endfunction

    state_t                      state_r;
    state_t                      state_next_s;
    logic [31:0]                 lfsr_r;
    logic [TS_WIDTH-1:0]         ts_r;
    logic [QB-1:0]               rr_ptr_r;
    logic [QB-1:0]               qid_r;
    logic [QB-1:0]               qid_sel_s;
    logic [NUM_QUEUES-1:0]       dst_s;
    logic [C_S_AXIS_DATA_WIDTH-1:0] hdr_data_s;

    logic                        wr_en_s;
    logic [LINE_W-1:0]           wr_line_s;
    logic                        hdr_wr_s;
    logic                        last_acc_s;
    logic                        tready_s;

    logic [LINE_W-1:0]           mem_r [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]  wr_ptr_r;
    logic [FIFO_DEPTH_BITS-1:0]  rd_ptr_r;
    logic [FIFO_DEPTH_BITS:0]    count_r;
    logic [FIFO_DEPTH_BITS:0]    count_next_s;
    logic                        full_r;
    logic                        empty_r;
    logic                        do_rd_s;
    logic [LINE_W-1:0]           head_s;

    logic [31:0]                 pkt_cnt_r [NUM_QUEUES];

    // Only the low 64 bits and the destination-port field of tuser matter
    logic unused_tuser_s;
    assign unused_tuser_s = ^s_axis_tuser;

    assign dst_s = s_axis_tuser[DST_PORT_POS +: NUM_QUEUES];

    // Metadata line: zeros above, timestamp in the middle, tuser[63:0] at the bottom
    always_comb begin
        hdr_data_s = '0;
        hdr_data_s[63:0] = s_axis_tuser[63:0];
        hdr_data_s[64 +: TS_WIDTH] = ts_r;
    end

    // Queue selection for a header written this cycle; lowest matching index wins
    always_comb begin
        qid_sel_s = '0;
        case (split_mode)
            2'd0: begin
                qid_sel_s = QID_LAST;
                for (int i = NUM_QUEUES - 2; i >= 0; i--) begin
                    qid_sel_s = (lfsr_r <= split_ratio[32*i +: 32]) ? QB'(i) : qid_sel_s;
                end
            end
            2'd1: begin
                qid_sel_s = rr_ptr_r;
            end
            2'd2: begin
                qid_sel_s = '0;
                for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
                    qid_sel_s = dst_s[i] ? QB'(i) : qid_sel_s;
                end
            end
            default: begin
                qid_sel_s = '0;
            end
        endcase
    end

    // Packet FSM: header insertion then beat forwarding, driving the FIFO write port
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        wr_line_s    = '0;
        hdr_wr_s     = 1'b0;
        last_acc_s   = 1'b0;
        tready_s     = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (s_axis_tvalid && !full_r) begin
                    wr_en_s      = 1'b1;
                    hdr_wr_s     = 1'b1;
                    wr_line_s    = {hdr_data_s, {STRB_W{1'b0}}, 1'b1, 1'b0, qid_sel_s};
                    state_next_s = ST_PKT;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_PKT: begin
                tready_s = !full_r;
                if (s_axis_tvalid && !full_r) begin
                    wr_en_s   = 1'b1;
                    wr_line_s = {s_axis_tdata, s_axis_tstrb, 1'b0, s_axis_tlast, qid_r};
                    if (s_axis_tlast) begin
                        last_acc_s   = 1'b1;
                        state_next_s = ST_HDR;
                    end else begin
                        state_next_s = ST_PKT;
                    end
                end else begin
                    state_next_s = ST_PKT;
                end
            end
            default: begin
                state_next_s = ST_HDR;
            end
        endcase
    end

    assign s_axis_tready = tready_s;

    // FSM state register
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Free-running LFSR, runs regardless of split mode
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            lfsr_r <= 32'hffff_ffff;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Free-running wrapping timestamp
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_ONE;
        end
    end

    // Round-robin pointer advances only when a header is written in round-robin mode
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            rr_ptr_r <= '0;
        end else if (hdr_wr_s && (split_mode == 2'd1)) begin
            rr_ptr_r <= (rr_ptr_r == QID_LAST) ? '0 : (rr_ptr_r + QID_ONE);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // QID latched at the header and held for every line of the packet
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            qid_r <= '0;
        end else if (hdr_wr_s) begin
            qid_r <= qid_sel_s;
        end else begin
            qid_r <= qid_r;
        end
    end

    // FIFO occupancy; writes are already gated by !full so a full FIFO only drains
    assign do_rd_s = fifo_rd_en && !empty_r;

    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, do_rd_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers and registered count/full/empty flags
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r <= do_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CNT_FULL);
            empty_r  <= (count_next_s == CNT_ZERO);
        end
    end

    // FIFO storage; contents need no reset because the pointers and count do
    always_ff @(posedge axi_aclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_line_s;
        end
    end

    // Fall-through head; all fields read as zero while empty
    assign head_s         = empty_r ? '0 : mem_r[rd_ptr_r];
    assign fifo_dout      = head_s[POS_DATA +: C_S_AXIS_DATA_WIDTH];
    assign fifo_dout_strb = head_s[POS_STRB +: STRB_W];
    assign fifo_dout_hdr  = head_s[POS_HDR];
    assign fifo_dout_last = head_s[POS_LAST];
    assign fifo_dout_qid  = head_s[QB-1:0];
    assign fifo_empty     = empty_r;

    // Per-queue packet counters; clear has priority over a coinciding increment
    always_ff @(posedge axi_aclk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (axi_areset || clear_counters) begin
                pkt_cnt_r[q] <= 32'd0;
            end else if (last_acc_s && (qid_r == QB'(q))) begin
                pkt_cnt_r[q] <= pkt_cnt_r[q] + 32'd1;
            end else begin
                pkt_cnt_r[q] <= pkt_cnt_r[q];
            end
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt_out
        assign pkt_count[32*g +: 32] = pkt_cnt_r[g];
    end

endmodule

// File: tb/tb_axis_pkt_queue_splitter.sv
// Scoreboard bench for axis_pkt_queue_splitter: the stimulus task pushes the
// expected FIFO lines, an independent monitor pops and compares each popped line.
module tb_axis_pkt_queue_splitter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NQ = 4;
    localparam int QB = 2;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              axi_areset;
    logic [DW-1:0]     s_axis_tdata;
    logic [SW-1:0]     s_axis_tstrb;
    logic [UW-1:0]     s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic              fifo_rd_en;
    logic [DW-1:0]     fifo_dout;
    logic [SW-1:0]     fifo_dout_strb;
    logic              fifo_dout_hdr;
    logic              fifo_dout_last;
    logic [QB-1:0]     fifo_dout_qid;
    logic              fifo_empty;
    logic [1:0]        split_mode;
    logic [32*(NQ-1)-1:0] split_ratio;
    logic              clear_counters;
    logic [32*NQ-1:0]  pkt_count;

    always #5 clk = ~clk;

    axis_pkt_queue_splitter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_QUEUES          (NQ),
        .NUM_QUEUES_BITS     (QB),
        .FIFO_DEPTH_BITS     (5),
        .TS_WIDTH            (64),
        .DST_PORT_POS        (24)
    ) dut (
        .axi_aclk      (clk),
        .axi_areset    (axi_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .fifo_dout_strb(fifo_dout_strb),
        .fifo_dout_hdr (fifo_dout_hdr),
        .fifo_dout_last(fifo_dout_last),
        .fifo_dout_qid (fifo_dout_qid),
        .fifo_empty    (fifo_empty),
        .split_mode    (split_mode),
        .split_ratio   (split_ratio),
        .clear_counters(clear_counters),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          hdr;
        logic          last;
        logic [QB-1:0] qid;
    } line_t;

    line_t       exp_q[$];
    line_t       mon_e;
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    bit          pkt_done = 1'b0;
    logic [63:0] tsm;

    // Reference timestamp: zero under reset, +1 per cycle
    always @(posedge clk) begin
        if (axi_areset) tsm <= 64'd0;
        else            tsm <= tsm + 64'd1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int pid, input int b);
        logic [15:0] p;
        logic [15:0] q;
        p = pid[15:0];
        q = b[15:0];
        return {8{p, q}};
    endfunction

    // Monitor: every line popped by the DUT is compared with the scoreboard head
    always @(negedge clk) begin
        if (!axi_areset && fifo_rd_en && !fifo_empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line: got qid %0d hdr %0b, expected no line", fifo_dout_qid, fifo_dout_hdr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("line_hdr",  DW'(fifo_dout_hdr),  DW'(mon_e.hdr));
                chk("line_last", DW'(fifo_dout_last), DW'(mon_e.last));
                chk("line_qid",  DW'(fifo_dout_qid),  DW'(mon_e.qid));
                chk("line_strb", DW'(fifo_dout_strb), DW'(mon_e.strb));
                chk("line_data", fifo_dout, mon_e.data);
            end
        end
    end

    // Sends one packet; header expected with the current timestamp, optional reset at a beat
    task automatic send_pkt(input int pid, input int len, input logic [UW-1:0] user,
                            input logic [QB-1:0] q, input int rst_at, input bit clr_last);
        line_t e;
        bit    ok;
        int    wc;
        pkt_done = 1'b0;
        acc_cnt  = 0;
        e.data = '0;
        e.data[63:0]   = user[63:0];
        e.data[127:64] = tsm;
        e.strb = '0;
        e.hdr  = 1'b1;
        e.last = 1'b0;
        e.qid  = q;
        exp_q.push_back(e);
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        for (int b = 0; b < len; b++) begin
            s_axis_tdata = mk_data(pid, b);
            s_axis_tstrb = (b == len - 1) ? 32'h0000_ffff : 32'hffff_ffff;
            s_axis_tlast = (b == len - 1);
            if (b == rst_at) begin
                axi_areset    = 1'b1;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                exp_q.delete();
                pkt_done = 1'b1;
                return;
            end
            clear_counters = clr_last && (b == len - 1);
            ok = 1'b0;
            wc = 0;
            while (!ok && wc < 300) begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                wc++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: pkt %0d beat %0d not accepted, expected within 300 cycles", pid, b);
                s_axis_tvalid  = 1'b0;
                s_axis_tlast   = 1'b0;
                clear_counters = 1'b0;
                pkt_done = 1'b1;
                return;
            end
            e.data = mk_data(pid, b);
            e.strb = (b == len - 1) ? 32'h0000_ffff : 32'hffff_ffff;
            e.hdr  = 1'b0;
            e.last = (b == len - 1);
            e.qid  = q;
            exp_q.push_back(e);
            acc_cnt++;
        end
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        clear_counters = 1'b0;
        pkt_done = 1'b1;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_remaining", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic do_reset();
        axi_areset    = 1'b1;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        axi_areset = 1'b0;
    endtask

    task automatic chk_cnt(input string name, input int q, input logic [31:0] exp);
        chk(name, DW'(pkt_count[32*q +: 32]), DW'(exp));
    endtask

    initial begin
        axi_areset     = 1'b1;
        s_axis_tdata   = '0;
        s_axis_tstrb   = '0;
        s_axis_tuser   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        fifo_rd_en     = 1'b0;
        split_mode     = 2'd1;
        split_ratio    = '0;
        clear_counters = 1'b0;
        do_reset();

        // Reset state
        chk("rst_tready", DW'(s_axis_tready), DW'(1'b0));
        chk("rst_empty",  DW'(fifo_empty),    DW'(1'b1));
        chk("rst_hdr",    DW'(fifo_dout_hdr), DW'(1'b0));
        chk("rst_last",   DW'(fifo_dout_last), DW'(1'b0));
        chk("rst_qid",    DW'(fifo_dout_qid), DW'(2'd0));
        chk("rst_strb",   DW'(fifo_dout_strb), DW'(32'd0));
        for (int q = 0; q < NQ; q++) chk_cnt("rst_pkt_count", q, 32'd0);

        // Round-robin: QIDs 0,1,2,3
        fifo_rd_en = 1'b1;
        split_mode = 2'd1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(p, 3, {64'hCAFE_0000_0000_0000 + 64'(p), 64'h1111_2222_3333_0000 + 64'(p)}, QB'(p), -1, 1'b0);
        end
        drain();
        for (int q = 0; q < NQ; q++) chk_cnt("rr_pkt_count", q, 32'd1);

        // Destination-port split: bit 26 set -> queue 2, field zero -> queue 0
        split_mode = 2'd2;
        send_pkt(10, 2, {64'hDEAD_BEEF_0000_0001, 64'hA5A5_0000_04AB_CDEF}, 2'd2, -1, 1'b0);
        send_pkt(11, 1, {64'hDEAD_BEEF_0000_0002, 64'h1234_5678_F0AB_CDEF}, 2'd0, -1, 1'b0);
        drain();
        chk_cnt("dst_pkt_count_q2", 2, 32'd2);
        chk_cnt("dst_pkt_count_q0", 0, 32'd2);
        chk_cnt("dst_pkt_count_q1", 1, 32'd1);

        // Weighted random: lfsr all-ones right after reset exceeds every ratio -> queue 3
        split_mode  = 2'd0;
        split_ratio = {32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000};
        do_reset();
        send_pkt(20, 2, {64'h0, 64'h0000_0000_0000_0020}, 2'd3, -1, 1'b0);
        split_ratio = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_pkt(21, 2, {64'h0, 64'h0000_0000_0000_0021}, 2'd0, -1, 1'b0);
        send_pkt(22, 1, {64'h0, 64'h0000_0000_0000_0022}, 2'd0, -1, 1'b0);
        // Reserved mode -> queue 0 even with a destination bit set
        split_mode = 2'd3;
        send_pkt(23, 1, {64'h0, 64'h0000_0000_0800_0023}, 2'd0, -1, 1'b0);
        drain();
        chk_cnt("wr_pkt_count_q3", 3, 32'd1);
        chk_cnt("wr_pkt_count_q0", 0, 32'd3);

        // Backpressure: no reads, 40-beat packet fills 32 lines (header + 31 beats)
        split_mode = 2'd1;
        fifo_rd_en = 1'b0;
        fork
            send_pkt(30, 40, {64'h0, 64'h0000_0000_0000_0030}, 2'd0, -1, 1'b0);
        join_none
        repeat (60) @(posedge clk);
        #1;
        chk("bp_beats_accepted", DW'(acc_cnt), DW'(31));
        chk("bp_tready_low", DW'(s_axis_tready), DW'(1'b0));
        chk("bp_not_empty", DW'(fifo_empty), DW'(1'b0));
        fifo_rd_en = 1'b1;
        @(posedge clk);
        #1;
        fifo_rd_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_one_more_beat", DW'(acc_cnt), DW'(32));
        chk("bp_tready_low_again", DW'(s_axis_tready), DW'(1'b0));
        fifo_rd_en = 1'b1;
        for (int w = 0; w < 400 && !pkt_done; w++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_pkt_done", DW'(pkt_done), DW'(1'b1));
        drain();
        chk_cnt("bp_pkt_count_q0", 0, 32'd4);

        // Reset on beat 5 of 10 with the FIFO holding lines
        fifo_rd_en = 1'b0;
        send_pkt(40, 10, {64'h0, 64'h0000_0000_0000_0040}, 2'd1, 4, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_empty", DW'(fifo_empty), DW'(1'b1));
        chk("mid_rst_tready", DW'(s_axis_tready), DW'(1'b0));
        for (int q = 0; q < NQ; q++) chk_cnt("mid_rst_pkt_count", q, 32'd0);
        axi_areset = 1'b0;
        fifo_rd_en = 1'b1;
        send_pkt(41, 2, {64'h0, 64'h0000_0000_0000_0041}, 2'd0, -1, 1'b0);
        drain();
        chk_cnt("post_rst_pkt_count_q0", 0, 32'd1);

        // Clear coinciding with a tlast acceptance wins over the increment
        send_pkt(42, 2, {64'h0, 64'h0000_0000_0000_0042}, 2'd1, -1, 1'b0);
        drain();
        chk_cnt("pre_clr_pkt_count_q1", 1, 32'd1);
        send_pkt(43, 3, {64'h0, 64'h0000_0000_0000_0043}, 2'd2, -1, 1'b1);
        drain();
        chk_cnt("clr_pkt_count_q2", 2, 32'd0);
        chk_cnt("clr_pkt_count_q1", 1, 32'd0);
        chk_cnt("clr_pkt_count_q0", 0, 32'd0);
        send_pkt(44, 1, {64'h0, 64'h0000_0000_0000_0044}, 2'd3, -1, 1'b0);
        drain();
        chk_cnt("post_clr_pkt_count_q3", 3, 32'd1);
        chk_cnt("post_clr_pkt_count_q2", 2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pkt_queue_splitter.md
# axis_pkt_queue_splitter

Single-clock, parametrised successor to the AXIS-to-FIFO replay stage. It accepts AXI-Stream packets and prepends one metadata line to each packet: timestamp plus low tuser. It assigns each packet a queue ID using a selectable split policy and buffers everything in an internal fall-through FIFO with per-line QID, header and end-of-packet sideband. The block sits between the pcap replay DMA stream and the per-queue memory/replay engines, and also keeps per-queue packet counters.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; must be ≥ 64+TS_WIDTH
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; must be ≥ 64 and > DST_PORT_POS+NUM_QUEUES
- NUM_QUEUES, 4, number of output queues, 2..16
- NUM_QUEUES_BITS, log2(NUM_QUEUES), QID width
- FIFO_DEPTH_BITS, 5, FIFO depth = 2**FIFO_DEPTH_BITS lines
- TS_WIDTH, 64, timestamp counter width
- DST_PORT_POS, 24, LSB of one-hot destination-port field in tuser
- axi_aclk  in  1  sole clock, all logic rising-edge
- axi_areset  in  1  synchronous, active-high reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet data
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  packet metadata, sampled on first beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&&tready
- s_axis_tlast  in  1  last beat of packet
- fifo_rd_en  in  1  pop head line
- fifo_dout  out  C_S_AXIS_DATA_WIDTH  head line data
- fifo_dout_strb  out  C_S_AXIS_DATA_WIDTH/8  head line strobes (0 for header)
- fifo_dout_hdr  out  1  head line is a metadata header
- fifo_dout_last  out  1  head line is last data line of packet
- fifo_dout_qid  out  NUM_QUEUES_BITS  queue of head line
- fifo_empty  out  1  FIFO empty
- split_mode  in  2  0 weighted-random, 1 round-robin, 2 tuser dst-port, 3 reserved→queue 0
- split_ratio  in  32*(NUM_QUEUES-1)  packed ascending thresholds, ratio_i = bits [32i+31:32i]
- clear_counters  in  1  synchronous clear of pkt_count
- pkt_count  out  32*NUM_QUEUES  packed per-queue packet counts, queue q at [32q+31:32q]

## Operation
- Two-state FSM: HDR (reset) and PKT.
- HDR: s_axis_tready=0. When s_axis_tvalid && !fifo_full, write header line {zeros, timestamp, s_axis_tuser[63:0]}, strb=0, hdr=1, last=0, and the QID chosen this cycle. Then go to PKT. The beat is not consumed.
- PKT: s_axis_tready = !fifo_full. Each accepted beat writes {tdata, tstrb, hdr=0, last=tlast, qid_r}. An accepted tlast beat returns the FSM to HDR and increments pkt_count[qid_r].
- QID selection is sampled only at the header write and held in qid_r for the whole packet.
  - Mode 0: lowest i with lfsr ≤ ratio_i, else NUM_QUEUES-1.
  - Mode 1: rr_ptr, then rr_ptr ← rr_ptr+1, wrapping at NUM_QUEUES-1→0.
  - Mode 2: index of the lowest set bit in tuser[DST_PORT_POS+NUM_QUEUES-1:DST_PORT_POS]; all-zero gives queue 0.
  - split_mode changes mid-packet have no effect until the next header.
- LFSR: 32-bit, reset 32'hffffffff, shifts right every cycle, new bit31 = b31^b6^b4^b2^b1^b0. It runs in all modes.
- timestamp: TS_WIDTH counter, reset 0, +1 every cycle, wraps.
- FIFO: synchronous, fall-through, width C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8 + 2 + NUM_QUEUES_BITS, depth 2**FIFO_DEPTH_BITS.
  - full = (count == depth).
  - Write only when !full; fifo_rd_en is ignored when empty.
  - Simultaneous read and write leaves count unchanged; when full, only the read takes effect that cycle.
- pkt_count: 32-bit wrapping. When clear_counters coincides with an increment, clear wins.

## Timing
- Reset values: s_axis_tready=0, fifo_empty=1, fifo_dout_hdr/last/qid/strb = 0, pkt_count all 0, rr_ptr=0, state HDR.
- Reset mid-packet flushes the FIFO and drops the partial packet. Upstream is reset together with this block.
- FIFO count and full are registered. A write at edge N clears fifo_empty after edge N, and fifo_dout shows that line in the same cycle.
- A pop at edge N presents the next line after edge N.
- First tvalid to first data-beat acceptance: 1 cycle (header bubble). A back-to-back packet costs 1 extra cycle per packet.
- With the FIFO never full and tvalid held: one header plus L beats take L+1 cycles.
- fifo_full deasserts the cycle after a pop from full, and s_axis_tready rises in the same cycle.

## Test plan
- Mode 1, four 3-beat packets, rd_en=1 → header QIDs 0,1,2,3, each followed by 3 data lines with last only on the 3rd; pkt_count each = 1.
- Mode 2, tuser[27:24]=4'b0100 then 4'b0000 → QID 2 then QID 0; header data[63:0] equals tuser[63:0] and data[127:64] equals the timestamp at the write cycle.
- Mode 0, ratios {0,0,32'hFFFFFFFE} after reset (lfsr=32'hffffffff) → first packet QID 3; ratios all 32'hFFFFFFFF → all packets QID 0.
- rd_en=0, FIFO_DEPTH_BITS=5, 40-beat packet → exactly 32 lines written, tready=0 held; one pop → exactly one more beat accepted.
- Reset asserted on beat 5 of 10 → fifo_empty=1, counters 0, tready=0 next cycle; a following 2-beat packet yields header plus 2 lines with QID 0.
- clear_counters asserted in the same cycle as a tlast acceptance → pkt_count for that queue reads 0 afterwards.
